// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with standard/FWFT read modes, programmable thresholds.
// Optional sticky overflow/underflow flags enabled by macro PARAM_SYNC_FIFO_ERR_FLAGS_EN.
`default_nettype none

module param_sync_fifo #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 64,
    parameter int FWFT       = 0
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    SOFT_CLR,
    input  logic                    WE,
    input  logic [DATA_WIDTH-1:0]   DIN,
    output logic                    FULL,
    output logic                    PROG_FULL,
    input  logic                    RE,
    output logic [DATA_WIDTH-1:0]   DOUT,
    output logic                    VALID,
    output logic                    EMPTY,
    output logic                    PROG_EMPTY,
    output logic [$clog2(DEPTH):0]  DATA_COUNT,
    input  logic [$clog2(DEPTH):0]  PROG_FULL_THRESH,
    input  logic [$clog2(DEPTH):0]  PROG_EMPTY_THRESH,
    input  logic                    ERR_CLR,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_ok = WE && !FULL;
    assign rd_ok = RE && !EMPTY;

    assign DATA_COUNT = count;
    assign FULL       = (count == CW'(DEPTH));
    assign EMPTY      = (count == '0);
    assign PROG_FULL  = (count >= PROG_FULL_THRESH);
    assign PROG_EMPTY = (count <= PROG_EMPTY_THRESH);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (SOFT_CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (wr_ok && RSTN && !SOFT_CLR) mem[wr_ptr] <= DIN;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; masked to zero while empty so reset presents DOUT=0.
            assign DOUT  = EMPTY ? '0 : mem[rd_ptr];
            assign VALID = !EMPTY;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  valid_q;

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else if (SOFT_CLR) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_ok;
                    if (rd_ok) dout_q <= mem[rd_ptr];
                end
            end

            assign DOUT  = dout_q;
            assign VALID = valid_q;
        end
    endgenerate

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    // A new error event in the same cycle as ERR_CLR keeps the flag set.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (SOFT_CLR) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (WE && FULL)  || (ovf_q && !ERR_CLR);
            unf_q <= (RE && EMPTY) || (unf_q && !ERR_CLR);
        end
    end

    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = ERR_CLR;
    assign OVERFLOW       = 1'b0;
    assign UNDERFLOW      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: table-driven plus scoreboard checks of param_sync_fifo (DEPTH=16, DATA_WIDTH=32).
`timescale 1ns/1ps
`default_nettype none

module tb_param_sync_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int CW    = 5;
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          SOFT_CLR = 1'b0, WE = 1'b0, RE = 1'b0, ERR_CLR = 1'b0;
    logic [DW-1:0] DIN = '0;
    logic [CW-1:0] pf_th = 5'd14, pe_th = 5'd2;
    logic          FULL, PROG_FULL, VALID, EMPTY, PROG_EMPTY, OVERFLOW, UNDERFLOW;
    logic [DW-1:0] DOUT;
    logic [CW-1:0] DATA_COUNT;

    logic          we_f = 1'b0, re_f = 1'b0;
    logic [DW-1:0] din_f = '0;
    logic          full_f, pfull_f, valid_f, empty_f, pempty_f, ovf_f, unf_f;
    logic [DW-1:0] dout_f;
    logic [CW-1:0] cnt_f;

    param_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) dut (
        .CLK(CLK), .RSTN(RSTN), .SOFT_CLR(SOFT_CLR), .WE(WE), .DIN(DIN),
        .FULL(FULL), .PROG_FULL(PROG_FULL), .RE(RE), .DOUT(DOUT), .VALID(VALID),
        .EMPTY(EMPTY), .PROG_EMPTY(PROG_EMPTY), .DATA_COUNT(DATA_COUNT),
        .PROG_FULL_THRESH(pf_th), .PROG_EMPTY_THRESH(pe_th), .ERR_CLR(ERR_CLR),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    param_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) dut_f (
        .CLK(CLK), .RSTN(RSTN), .SOFT_CLR(1'b0), .WE(we_f), .DIN(din_f),
        .FULL(full_f), .PROG_FULL(pfull_f), .RE(re_f), .DOUT(dout_f), .VALID(valid_f),
        .EMPTY(empty_f), .PROG_EMPTY(pempty_f), .DATA_COUNT(cnt_f),
        .PROG_FULL_THRESH(5'd14), .PROG_EMPTY_THRESH(5'd2), .ERR_CLR(1'b0),
        .OVERFLOW(ovf_f), .UNDERFLOW(unf_f)
    );

    always #5 CLK = ~CLK;

    int            total = 0;
    int            bad = 0;
    int            mcount;
    logic [DW-1:0] q[$];
    logic          exp_valid, exp_ovf, exp_unf;
    logic [DW-1:0] exp_dout;

    typedef struct {
        bit          we;
        bit          re;
        logic [31:0] din;
        int          cnt;
        bit          full;
        bit          pf;
        bit          pe;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mcount    = 0;
        exp_valid = 1'b0;
        exp_dout  = '0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic check_outputs();
        chk("count", DATA_COUNT, mcount);
        chk("full", FULL, mcount == DEPTH);
        chk("empty", EMPTY, mcount == 0);
        chk("prog_full", PROG_FULL, mcount >= int'(pf_th));
        chk("prog_empty", PROG_EMPTY, mcount <= int'(pe_th));
        chk("valid", VALID, exp_valid);
        chk("dout", DOUT, exp_dout);
        chk("overflow", OVERFLOW, exp_ovf);
        chk("underflow", UNDERFLOW, exp_unf);
    endtask

    // One clock: drive, update scoreboard at the edge, compare 1ns later.
    task automatic cycle(input bit we, input logic [31:0] d, input bit re,
                         input bit sc = 1'b0, input bit ec = 1'b0);
        bit wa, ra;
        WE = we; DIN = d; RE = re; SOFT_CLR = sc; ERR_CLR = ec;
        @(posedge CLK);
        if (sc) begin
            model_reset();
        end else begin
            wa = we && (mcount < DEPTH);
            ra = re && (mcount > 0);
            if (ERR_EN) begin
                exp_ovf = (we && mcount == DEPTH) || (exp_ovf && !ec);
                exp_unf = (re && mcount == 0) || (exp_unf && !ec);
            end
            exp_valid = ra;
            if (ra) exp_dout = q.pop_front();
            if (wa) q.push_back(d);
            mcount = q.size();
        end
        #1;
        check_outputs();
        WE = 1'b0; RE = 1'b0; SOFT_CLR = 1'b0; ERR_CLR = 1'b0;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 16; i++)
            tbl[i] = '{we: 1'b1, re: 1'b0, din: 32'(i + 1), cnt: i + 1,
                       full: (i == 15), pf: (i + 1 >= 14), pe: (i + 1 <= 2)};
        for (int i = 16; i < 19; i++)
            tbl[i] = '{we: 1'b1, re: 1'b0, din: 32'hDEAD_0000 + 32'(i), cnt: 16,
                       full: 1'b1, pf: 1'b1, pe: 1'b0};

        // Reset state while RSTN is held low.
        #2;
        check_outputs();
        chk("rst_prog_empty", PROG_EMPTY, 1);
        chk("rst_fwft_valid", valid_f, 0);
        chk("rst_fwft_dout", dout_f, 0);
        #10 RSTN = 1'b1;

        // Fill to full, then three writes while full.
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].we, tbl[i].din, tbl[i].re);
            chk("tbl_cnt", DATA_COUNT, tbl[i].cnt);
            chk("tbl_full", FULL, tbl[i].full);
            chk("tbl_pf", PROG_FULL, tbl[i].pf);
            chk("tbl_pe", PROG_EMPTY, tbl[i].pe);
        end
        cycle(0, 0, 0);
        chk("ovf_sticky", OVERFLOW, ERR_EN);
        cycle(1, 32'hBAD, 0, 0, 1);
        chk("ovf_set_wins", OVERFLOW, ERR_EN);
        cycle(0, 0, 0, 0, 1);
        chk("ovf_cleared", OVERFLOW, 0);

        // Drain 16 plus 2 extra reads; scoreboard checks DOUT/VALID order.
        for (int i = 0; i < 18; i++) cycle(0, 0, 1);
        chk("unf_sticky", UNDERFLOW, ERR_EN);
        cycle(0, 0, 0, 0, 1);

        // Runtime thresholds are decoded without latency.
        for (int i = 0; i < 8; i++) cycle(1, 32'h50 + 32'(i), 0);
        pf_th = 5'd5; #1;
        chk("pf_runtime", PROG_FULL, 1);
        pe_th = 5'd9; #1;
        chk("pe_runtime", PROG_EMPTY, 1);
        pf_th = 5'd14; pe_th = 5'd2; #1;
        chk("pf_restore", PROG_FULL, 0);
        chk("pe_restore", PROG_EMPTY, 0);

        // Simultaneous write/read at count 8 for 20 cycles: pointers wrap.
        for (int i = 0; i < 20; i++) cycle(1, 32'h100 + 32'(i), 1);
        chk("rw_count", DATA_COUNT, 8);

        // Async reset mid-burst at count 10.
        cycle(1, 32'h200, 0);
        cycle(1, 32'h201, 0);
        WE = 1'b1; DIN = 32'h202;
        #2 RSTN = 1'b0;
        #1;
        model_reset();
        check_outputs();
        RSTN = 1'b1;
        cycle(1, 32'h77, 0);
        chk("post_rst_write", DATA_COUNT, 1);
        cycle(0, 0, 1);

        // Soft clear at count 10 overrides WE/RE.
        for (int i = 0; i < 10; i++) cycle(1, 32'h300 + 32'(i), 0);
        cycle(1, 32'h3FF, 1, 1);
        cycle(1, 32'h400, 0);
        cycle(0, 0, 1);

        // FWFT instance.
        we_f = 1'b1; din_f = 32'hA5;
        @(posedge CLK); #1;
        we_f = 1'b0;
        chk("fwft_dout", dout_f, 32'hA5);
        chk("fwft_valid", valid_f, 1);
        re_f = 1'b1;
        @(posedge CLK); #1;
        re_f = 1'b0;
        chk("fwft_empty", empty_f, 1);
        chk("fwft_valid_off", valid_f, 0);
        we_f = 1'b1; din_f = 32'hB1;
        @(posedge CLK); #1;
        din_f = 32'hB2;
        @(posedge CLK); #1;
        we_f = 1'b0;
        chk("fwft_head", dout_f, 32'hB1);
        re_f = 1'b1;
        @(posedge CLK); #1;
        chk("fwft_next", dout_f, 32'hB2);
        @(posedge CLK); #1;
        chk("fwft_drained", empty_f, 1);
        @(posedge CLK); #1;
        re_f = 1'b0;
        chk("fwft_unf", unf_f, ERR_EN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
